// File: rtl/lenet_pkg.sv
// lenet_pkg: shared widths, outstanding-read limit and client identifiers for the DRAM arbiter.
package lenet_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 18;
   localparam int MAX_OUTST = 4;
   typedef enum logic {CLIENT_FEAT = 1'b0, CLIENT_WGT = 1'b1} client_id_t;
   function automatic logic [1:0] client_onehot(input client_id_t c);
      return c == CLIENT_WGT ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/rd_tag_fifo.sv
// rd_tag_fifo: in-order FIFO of client IDs for reads awaiting DRAM data.
module rd_tag_fifo #(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          push,
   input  logic          pop,
   input  logic          din,
   output logic          dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [DEPTH-1:0] mem;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign dout = mem[rd_ptr];
   assign do_pop = pop && !empty;
   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: independent round-robin read/write arbitration of two clients onto a DRAM port,
// with in-order routing of returned read data back to the requesting client.
module dram_arbiter #(
   parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = lenet_pkg::ADDR_WIDTH,
   parameter int MAX_OUTST = lenet_pkg::MAX_OUTST
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [1:0]            rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr0,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   output logic [1:0]            rd_ack,
   output logic [1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic [1:0]            wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr0,
   input  logic [ADDR_WIDTH-1:0] wr_addr1,
   input  logic [DATA_WIDTH-1:0] wr_data0,
   input  logic [DATA_WIDTH-1:0] wr_data1,
   output logic [1:0]            wr_ack,
   output logic                  dram_en_rd,
   output logic [ADDR_WIDTH-1:0] dram_addr_rd,
   input  logic                  dram_valid,
   input  logic [DATA_WIDTH-1:0] dram_data_rd,
   output logic                  dram_en_wr,
   output logic [ADDR_WIDTH-1:0] dram_addr_wr,
   output logic [DATA_WIDTH-1:0] dram_data_wr,
   output logic                  idle,
   output logic                  err_unexp
);
   import lenet_pkg::*;
   localparam int CW = $clog2(MAX_OUTST) + 1;
   client_id_t rd_last, wr_last, rd_pick, wr_pick, head;
   logic rd_grant, wr_grant, pop, full, empty, tag_out;
   logic [CW-1:0] count;
   // on a tie the client not granted last wins; reset leaves client 1 as "last"
   assign rd_pick = rd_req == 2'b11 ? client_id_t'(~rd_last) : client_id_t'(rd_req[1]);
   assign wr_pick = wr_req == 2'b11 ? client_id_t'(~wr_last) : client_id_t'(wr_req[1]);
   assign head = client_id_t'(tag_out);
   assign pop = dram_valid && !empty && !srst;
   assign rd_grant = !srst && |rd_req && (!full || pop);
   assign wr_grant = !srst && |wr_req;
   assign rd_ack = rd_grant ? client_onehot(rd_pick) : 2'b00;
   assign wr_ack = wr_grant ? client_onehot(wr_pick) : 2'b00;
   assign rd_valid = pop ? client_onehot(head) : 2'b00;
   assign rd_data = dram_data_rd;
   assign idle = srst || (count == '0 && !dram_en_rd && !dram_en_wr && rd_req == 2'b00 && wr_req == 2'b00);
   rd_tag_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
      .clk(clk),
      .srst(srst),
      .push(rd_grant),
      .pop(pop),
      .din(rd_pick),
      .dout(tag_out),
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge clk) begin
      if (srst) begin
         dram_en_rd <= 1'b0;
         dram_en_wr <= 1'b0;
         dram_addr_rd <= '0;
         dram_addr_wr <= '0;
         dram_data_wr <= '0;
         rd_last <= CLIENT_WGT;
         wr_last <= CLIENT_WGT;
         err_unexp <= 1'b0;
      end else begin
         dram_en_rd <= rd_grant;
         dram_en_wr <= wr_grant;
         if (rd_grant) begin
            dram_addr_rd <= rd_pick == CLIENT_WGT ? rd_addr1 : rd_addr0;
            rd_last <= rd_pick;
         end
         if (wr_grant) begin
            dram_addr_wr <= wr_pick == CLIENT_WGT ? wr_addr1 : wr_addr0;
            dram_data_wr <= wr_pick == CLIENT_WGT ? wr_data1 : wr_data0;
            wr_last <= wr_pick;
         end
         if (dram_valid && empty) err_unexp <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed checks of arbitration, tag routing, backpressure, reset and an end-to-end DRAM model.
module tb_dram_arbiter;
   logic clk = 1'b0, srst;
   logic [1:0] rd_req, wr_req, rd_ack, rd_valid, wr_ack;
   logic [17:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1, dram_addr_rd, dram_addr_wr;
   logic [31:0] wr_data0, wr_data1, rd_data, dram_data_rd, dram_data_wr;
   logic dram_en_rd, dram_en_wr, dram_valid, idle, err_unexp;
   logic auto_en, model_valid, manual_valid;
   logic [31:0] model_data, manual_data;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   dram_arbiter dut (
      .clk(clk), .srst(srst),
      .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
      .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
      .dram_valid(dram_valid), .dram_data_rd(dram_data_rd),
      .dram_en_wr(dram_en_wr), .dram_addr_wr(dram_addr_wr), .dram_data_wr(dram_data_wr),
      .idle(idle), .err_unexp(err_unexp)
   );

   assign dram_valid = model_valid | manual_valid;
   assign dram_data_rd = auto_en ? model_data : manual_data;

   // DRAM model: reads return 3 cycles after dram_en_rd; unwritten words read as a fixed pattern
   typedef struct {logic [17:0] a; int t;} ent_t;
   ent_t q[$];
   logic [31:0] mem [0:1023];
   bit written [0:1023];
   int cyc_n = 0;

   function automatic logic [31:0] dflt(input logic [17:0] a);
      return 32'hA5A5_0000 ^ {14'd0, a};
   endfunction

   function automatic logic [31:0] wdat(input logic [17:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   always @(negedge clk) begin
      cyc_n++;
      model_valid = 1'b0;
      if (q.size() > 0 && q[0].t == cyc_n) begin
         model_valid = 1'b1;
         model_data = written[q[0].a[9:0]] ? mem[q[0].a[9:0]] : dflt(q[0].a);
         void'(q.pop_front());
      end
      if (auto_en && dram_en_rd) q.push_back('{dram_addr_rd, cyc_n + 3});
      if (dram_en_wr) begin
         mem[dram_addr_wr[9:0]] = dram_data_wr;
         written[dram_addr_wr[9:0]] = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (!idle && k < 50);
      chk(tag, idle, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n0, n1, n_ret, guard, k;
      logic [33:0] sb[$];
      srst = 1'b1; rd_req = 2'b00; wr_req = 2'b00;
      rd_addr0 = '0; rd_addr1 = '0; wr_addr0 = '0; wr_addr1 = '0;
      wr_data0 = '0; wr_data1 = '0;
      auto_en = 1'b0; manual_valid = 1'b0; manual_data = '0;
      for (int i = 0; i < 1024; i++) written[i] = 1'b0;
      // reset: requests are masked while srst is high
      @(negedge clk);
      rd_req = 2'b11; wr_req = 2'b11;
      #1;
      chk("rst_rd_ack", rd_ack, 2'b00);
      chk("rst_wr_ack", wr_ack, 2'b00);
      chk("rst_idle", idle, 1);
      @(negedge clk);
      srst = 1'b0; rd_req = 2'b00; wr_req = 2'b00;
      #1;
      chk("rst_en_rd", dram_en_rd, 0);
      chk("rst_en_wr", dram_en_wr, 0);
      chk("rst_err", err_unexp, 0);
      chk("rst_idle_after", idle, 1);
      // both read clients held: acks alternate, returns follow ack order
      auto_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rd_req = i < 8 ? 2'b11 : 2'b00;
         rd_addr0 = 18'h100; rd_addr1 = 18'h200;
         #1;
         chk($sformatf("rr_ack_%0d", i), rd_ack, i >= 8 ? 2'b00 : (i % 2 == 1 ? 2'b10 : 2'b01));
         if (i >= 4) begin
            chk($sformatf("rr_valid_%0d", i), rd_valid, (i - 4) % 2 == 1 ? 2'b10 : 2'b01);
            chk($sformatf("rr_data_%0d", i), rd_data, (i - 4) % 2 == 1 ? dflt(18'h200) : dflt(18'h100));
         end
      end
      wait_idle("rr_idle");
      // simultaneous read and write grants
      @(negedge clk);
      rd_req = 2'b01; rd_addr0 = 18'h010;
      wr_req = 2'b11; wr_addr0 = 18'h020; wr_data0 = 32'hDEAD_0001;
      wr_addr1 = 18'h030; wr_data1 = 32'hBEEF_0002;
      #1;
      chk("rw_rd_ack", rd_ack, 2'b01);
      chk("rw_wr_ack", wr_ack, 2'b01);
      @(negedge clk);
      rd_req = 2'b00; wr_req = 2'b10;
      #1;
      chk("rw_en_rd", dram_en_rd, 1);
      chk("rw_addr_rd", dram_addr_rd, 18'h010);
      chk("rw_en_wr", dram_en_wr, 1);
      chk("rw_addr_wr", dram_addr_wr, 18'h020);
      chk("rw_data_wr", dram_data_wr, 32'hDEAD_0001);
      chk("rw_wr_ack2", wr_ack, 2'b10);
      @(negedge clk);
      wr_req = 2'b00;
      #1;
      chk("rw_en_rd_pulse", dram_en_rd, 0);
      chk("rw_en_wr2", dram_en_wr, 1);
      chk("rw_addr_wr2", dram_addr_wr, 18'h030);
      chk("rw_data_wr2", dram_data_wr, 32'hBEEF_0002);
      wait_idle("rw_idle");
      // outstanding limit: 5th read waits until a return frees a slot
      auto_en = 1'b0;
      k = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         rd_req = 2'b01; rd_addr0 = 18'h040 + 18'(k);
         manual_valid = i == 6; manual_data = 32'h5555_0001;
         #1;
         chk($sformatf("full_ack_%0d", i), rd_ack, (i < 4 || i == 6) ? 2'b01 : 2'b00);
         if (i == 4) chk("full_count", dut.u_fifo.count, 4);
         if (i == 6) begin
            chk("full_pop_valid", rd_valid, 2'b01);
            chk("full_pop_data", rd_data, 32'h5555_0001);
         end
         if (rd_ack[0]) k++;
      end
      @(negedge clk);
      rd_req = 2'b00; manual_valid = 1'b0;
      #1;
      chk("full_count_kept", dut.u_fifo.count, 4);
      chk("full_en_rd", dram_en_rd, 1);
      chk("full_addr_rd", dram_addr_rd, 18'h044);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         manual_valid = 1'b1; manual_data = 32'h6000_0000 + 32'(j);
         #1;
         chk($sformatf("drain_valid_%0d", j), rd_valid, 2'b01);
         chk($sformatf("drain_data_%0d", j), rd_data, 32'h6000_0000 + 32'(j));
      end
      @(negedge clk);
      manual_valid = 1'b0;
      wait_idle("drain_idle");
      // reset with 3 reads in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rd_req = 2'b01; rd_addr0 = 18'h050 + 18'(i);
         #1;
         chk($sformatf("pre_rst_ack_%0d", i), rd_ack, 2'b01);
      end
      @(negedge clk);
      srst = 1'b1; rd_req = 2'b11; manual_valid = 1'b1;
      #1;
      chk("mid_rst_ack", rd_ack, 2'b00);
      chk("mid_rst_valid", rd_valid, 2'b00);
      chk("mid_rst_idle", idle, 1);
      @(negedge clk);
      srst = 1'b0; rd_req = 2'b00; manual_valid = 1'b0;
      #1;
      chk("post_rst_count", dut.u_fifo.count, 0);
      chk("post_rst_idle", idle, 1);
      chk("post_rst_err", err_unexp, 0);
      @(negedge clk);
      manual_valid = 1'b1;
      #1;
      chk("unexp_valid", rd_valid, 2'b00);
      chk("unexp_idle", idle, 1);
      @(negedge clk);
      manual_valid = 1'b0;
      #1;
      chk("unexp_err", err_unexp, 1);
      chk("unexp_count", dut.u_fifo.count, 0);
      @(negedge clk);
      #1;
      chk("unexp_err_sticky", err_unexp, 1);
      @(negedge clk);
      rd_req = 2'b11; rd_addr0 = 18'h060; rd_addr1 = 18'h070;
      #1;
      chk("post_rst_tie", rd_ack, 2'b01);
      @(negedge clk);
      rd_req = 2'b00;
      #1;
      chk("post_rst_tie_addr", dram_addr_rd, 18'h060);
      @(negedge clk);
      manual_valid = 1'b1; manual_data = 32'h0000_0077;
      #1;
      chk("post_rst_ret", rd_valid, 2'b01);
      @(negedge clk);
      manual_valid = 1'b0;
      wait_idle("post_rst_idle2");
      // end to end: 64 writes by client 1, read back alternately by both read clients
      auto_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         wr_req = 2'b10; wr_addr1 = 18'(i); wr_data1 = wdat(18'(i));
         #1;
         chk($sformatf("e2e_wr_ack_%0d", i), wr_ack, 2'b10);
      end
      @(negedge clk);
      wr_req = 2'b00;
      @(negedge clk);
      n0 = 0; n1 = 0; n_ret = 0; guard = 0;
      while ((n0 < 32 || n1 < 32 || sb.size() > 0) && guard < 400) begin
         @(negedge clk);
         rd_req = {n1 < 32, n0 < 32};
         rd_addr0 = 18'(2 * n0); rd_addr1 = 18'(2 * n1 + 1);
         #1;
         if (rd_valid != 2'b00) begin
            if (sb.size() > 0) begin
               chk($sformatf("e2e_valid_%0d", n_ret), rd_valid, sb[0][33:32]);
               chk($sformatf("e2e_data_%0d", n_ret), rd_data, sb[0][31:0]);
               void'(sb.pop_front());
            end else chk("e2e_unexpected", rd_valid, 2'b00);
            n_ret++;
         end
         if (rd_ack == 2'b01) begin
            sb.push_back({2'b01, wdat(18'(2 * n0))});
            n0++;
         end else if (rd_ack == 2'b10) begin
            sb.push_back({2'b10, wdat(18'(2 * n1 + 1))});
            n1++;
         end
         guard++;
      end
      rd_req = 2'b00;
      chk("e2e_returns", n_ret, 64);
      wait_idle("e2e_idle");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
